// File: rtl/lobster_cache.sv
// lobster_cache: direct-mapped, write-allocate word cache. It sits in front of
// the execution manager as the I-cache. The fill port writes one word per line.
// The read port registers a lookup every cycle and returns the word with a miss flag.
//
// Ports:
//   clk       clock; all state changes on posedge
//   rst       synchronous reset, active-low
//   we        fill-port write enable
//   addr_in   fill-port word address
//   data_in   fill-port data
//   addr_out  read-port word address (an input despite the name)
//   data_out  registered read data (0 on miss)
//   inv       registered miss flag (1 = data_out invalid)
module lobster_cache #(
  parameter int unsigned ADDR_WIDTH = 36,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned NUM_LINES  = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [ADDR_WIDTH-1:0] addr_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  inv
);

  localparam int unsigned IDX_W = $clog2(NUM_LINES);
  localparam int unsigned TAG_W = ADDR_WIDTH - IDX_W;

  logic [NUM_LINES-1:0]  valid_q;
  logic [TAG_W-1:0]      tag_q  [NUM_LINES];
  logic [DATA_WIDTH-1:0] data_q [NUM_LINES];

  logic [IDX_W-1:0]      wr_idx_c;
  logic [TAG_W-1:0]      wr_tag_c;
  logic [IDX_W-1:0]      rd_idx_c;
  logic [TAG_W-1:0]      rd_tag_c;
  logic                  hit_c;
  logic [DATA_WIDTH-1:0] rd_data_c;

  // Address split into line index (low bits) and tag (high bits)
  assign wr_idx_c = addr_in[IDX_W-1:0];
  assign wr_tag_c = addr_in[ADDR_WIDTH-1:IDX_W];
  assign rd_idx_c = addr_out[IDX_W-1:0];
  assign rd_tag_c = addr_out[ADDR_WIDTH-1:IDX_W];

  // Lookup sees the post-write line when a fill targets the same index
  always_comb begin
    hit_c     = 1'b0;
    rd_data_c = '0;
    if (we && (wr_idx_c == rd_idx_c)) begin
      hit_c     = (wr_tag_c == rd_tag_c);
      rd_data_c = data_in;
    end else begin
      hit_c     = valid_q[rd_idx_c] && (tag_q[rd_idx_c] == rd_tag_c);
      rd_data_c = data_q[rd_idx_c];
    end
  end

  // Valid bits: the only storage cleared by reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= '0;
    end else if (we) begin
      valid_q[wr_idx_c] <= 1'b1;
    end
  end

  // Tag/data arrays: fill evicts unconditionally, no reset needed
  always_ff @(posedge clk) begin
    if (rst && we) begin
      tag_q[wr_idx_c]  <= wr_tag_c;
      data_q[wr_idx_c] <= data_in;
    end
  end

  // Registered read result
  always_ff @(posedge clk) begin
    if (!rst) begin
      data_out <= '0;
      inv      <= 1'b1;
    end else begin
      data_out <= hit_c ? rd_data_c : '0;
      inv      <= ~hit_c;
    end
  end

endmodule

// File: tb/tb_lobster_cache.sv
// tb_lobster_cache: self-checking bench for lobster_cache. It uses a reference
// model that keeps, for each line, the full stored address and its data.
module tb_lobster_cache;

  localparam int unsigned AW = 36;
  localparam int unsigned DW = 64;
  localparam int unsigned NL = 256;

  logic          clk;
  logic          rst;
  logic          we;
  logic [AW-1:0] addr_in;
  logic [DW-1:0] data_in;
  logic [AW-1:0] addr_out;
  logic [DW-1:0] data_out;
  logic          inv;

  int errors;
  int checks;

  // Reference model: line holds the whole address it was filled from
  bit            m_valid [NL];
  logic [AW-1:0] m_addr  [NL];
  logic [DW-1:0] m_data  [NL];
  logic [DW-1:0] exp_data;
  logic          exp_inv;

  lobster_cache #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_LINES(NL)) dut (
    .clk      (clk),
    .rst      (rst),
    .we       (we),
    .addr_in  (addr_in),
    .data_in  (data_in),
    .addr_out (addr_out),
    .data_out (data_out),
    .inv      (inv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int line_of(input logic [AW-1:0] a);
    return int'(a % AW'(NL));
  endfunction

  // One clock: drive inputs, clock them in, update model, settle outputs
  task automatic cycle(input logic r, input logic w, input logic [AW-1:0] ai,
                       input logic [DW-1:0] di, input logic [AW-1:0] ao);
    int li;
    int lr;
    rst = r; we = w; addr_in = ai; data_in = di; addr_out = ao;
    @(posedge clk);
    if (!r) begin
      for (int i = 0; i < int'(NL); i++) m_valid[i] = 1'b0;
      exp_data = '0;
      exp_inv  = 1'b1;
    end else begin
      if (w) begin
        li = line_of(ai);
        m_valid[li] = 1'b1;
        m_addr[li]  = ai;
        m_data[li]  = di;
      end
      lr = line_of(ao);
      if (m_valid[lr] && (m_addr[lr] == ao)) begin
        exp_data = m_data[lr];
        exp_inv  = 1'b0;
      end else begin
        exp_data = '0;
        exp_inv  = 1'b1;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    cycle(1'b0, 1'b1, 36'h5, 64'h1111, 36'h5);
    checks++;
    if (data_out !== 64'h0 || inv !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: data_out=%h inv=%b want data_out=0 inv=1", data_out, inv);
    end
    cycle(1'b1, 1'b0, 36'h0, 64'h0, 36'h5);
    checks++;
    if (data_out !== 64'h0 || inv !== 1'b1) begin
      errors++;
      $display("FAIL read_after_reset: data_out=%h inv=%b want data_out=0 inv=1", data_out, inv);
    end
  endtask

  task automatic test_basic();
    cycle(1'b1, 1'b1, 36'h10, 64'hDEADBEEF_CAFEF00D, 36'h7);
    checks++;
    if (inv !== 1'b1) begin
      errors++;
      $display("FAIL basic_other_miss: inv=%b want 1", inv);
    end
    cycle(1'b1, 1'b0, 36'h0, 64'h0, 36'h10);
    checks++;
    if (data_out !== 64'hDEADBEEF_CAFEF00D || inv !== 1'b0) begin
      errors++;
      $display("FAIL basic_hit: data_out=%h inv=%b want data_out=deadbeefcafef00d inv=0", data_out, inv);
    end
  endtask

  task automatic test_conflict();
    cycle(1'b1, 1'b1, 36'h10, 64'hAAAA_0000_AAAA_0001, 36'h0);
    cycle(1'b1, 1'b1, 36'h110, 64'hBBBB_0000_BBBB_0002, 36'h0);
    cycle(1'b1, 1'b0, 36'h0, 64'h0, 36'h10);
    checks++;
    if (data_out !== 64'h0 || inv !== 1'b1) begin
      errors++;
      $display("FAIL conflict_evicted: data_out=%h inv=%b want data_out=0 inv=1", data_out, inv);
    end
    cycle(1'b1, 1'b0, 36'h0, 64'h0, 36'h110);
    checks++;
    if (data_out !== 64'hBBBB_0000_BBBB_0002 || inv !== 1'b0) begin
      errors++;
      $display("FAIL conflict_new: data_out=%h inv=%b want data_out=bbbb0000bbbb0002 inv=0", data_out, inv);
    end
    // Same index, different tag, written in the read cycle: post-write miss
    cycle(1'b1, 1'b1, 36'h210, 64'hCCCC, 36'h110);
    checks++;
    if (data_out !== 64'h0 || inv !== 1'b1) begin
      errors++;
      $display("FAIL same_index_write: data_out=%h inv=%b want data_out=0 inv=1", data_out, inv);
    end
  endtask

  task automatic test_collision();
    cycle(1'b1, 1'b1, 36'h20, 64'h1234, 36'h20);
    checks++;
    if (data_out !== 64'h1234 || inv !== 1'b0) begin
      errors++;
      $display("FAIL collision: data_out=%h inv=%b want data_out=1234 inv=0", data_out, inv);
    end
    // Overwrite of an already-valid line in the same cycle as its read
    cycle(1'b1, 1'b1, 36'h20, 64'h5678, 36'h20);
    checks++;
    if (data_out !== 64'h5678 || inv !== 1'b0) begin
      errors++;
      $display("FAIL collision_overwrite: data_out=%h inv=%b want data_out=5678 inv=0", data_out, inv);
    end
  endtask

  task automatic test_reset_mid();
    int bad;
    for (int a = 0; a < int'(NL); a++)
      cycle(1'b1, 1'b1, AW'(a), DW'(64'h100 + a), 36'h0);
    cycle(1'b1, 1'b0, 36'h0, 64'h0, 36'h33);
    checks++;
    if (data_out !== 64'h133 || inv !== 1'b0) begin
      errors++;
      $display("FAIL fill_hit: data_out=%h inv=%b want data_out=133 inv=0", data_out, inv);
    end
    // Reset overrides a write presented in the same cycle
    cycle(1'b0, 1'b1, 36'h34, 64'h9999, 36'h34);
    bad = 0;
    for (int a = 0; a < int'(NL); a++) begin
      cycle(1'b1, 1'b0, 36'h0, 64'h0, AW'(a));
      checks++;
      if (inv !== 1'b1 || data_out !== 64'h0) begin
        errors++;
        bad++;
        if (bad < 5)
          $display("FAIL post_reset_read: addr=%0h data_out=%h inv=%b want data_out=0 inv=1", a, data_out, inv);
      end
    end
  endtask

  task automatic test_tag_width();
    cycle(1'b1, 1'b1, 36'hF_FFFF_FFFF, 64'hC0C0_C0C0_1234_5678, 36'h0);
    cycle(1'b1, 1'b0, 36'h0, 64'h0, 36'hF_FFFF_FFFF);
    checks++;
    if (data_out !== 64'hC0C0_C0C0_1234_5678 || inv !== 1'b0) begin
      errors++;
      $display("FAIL all_ones_hit: data_out=%h inv=%b want data_out=c0c0c0c012345678 inv=0", data_out, inv);
    end
    cycle(1'b1, 1'b0, 36'h0, 64'h0, 36'h0_0000_00FF);
    checks++;
    if (data_out !== 64'h0 || inv !== 1'b1) begin
      errors++;
      $display("FAIL all_ones_alias: data_out=%h inv=%b want data_out=0 inv=1", data_out, inv);
    end
    // Only the top tag bit differs
    cycle(1'b1, 1'b0, 36'h0, 64'h0, 36'h7_FFFF_FFFF);
    checks++;
    if (data_out !== 64'h0 || inv !== 1'b1) begin
      errors++;
      $display("FAIL tag_msb: data_out=%h inv=%b want data_out=0 inv=1", data_out, inv);
    end
  endtask

  function automatic logic [AW-1:0] rand_addr();
    logic [AW-1:0] t;
    logic [AW-1:0] ix;
    case ($urandom_range(0, 3))
      0: t = 36'h0;
      1: t = 36'h1;
      2: t = 36'hFFF_FFFF;
      default: t = AW'($urandom_range(0, 15));
    endcase
    ix = ($urandom_range(0, 9) == 0) ? AW'(NL - 1) : AW'($urandom_range(0, 7));
    return t * AW'(NL) + ix;
  endfunction

  task automatic test_random();
    logic          r;
    logic          w;
    logic [AW-1:0] ai;
    logic [AW-1:0] ao;
    logic [DW-1:0] di;
    for (int n = 0; n < 3000; n++) begin
      r  = ($urandom_range(0, 299) != 0);
      w  = ($urandom_range(0, 1) == 1);
      ai = rand_addr();
      ao = ($urandom_range(0, 5) == 0) ? ai : rand_addr();
      di = {32'($urandom), 32'($urandom)};
      cycle(r, w, ai, di, ao);
      checks++;
      if (data_out !== exp_data || inv !== exp_inv) begin
        errors++;
        $display("FAIL random[%0d]: ao=%h data_out=%h inv=%b want data_out=%h inv=%b",
                 n, ao, data_out, inv, exp_data, exp_inv);
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b0; we = 1'b0; addr_in = '0; data_in = '0; addr_out = '0;
    exp_data = '0;
    exp_inv  = 1'b1;
    for (int i = 0; i < int'(NL); i++) begin
      m_valid[i] = 1'b0;
      m_addr[i]  = '0;
      m_data[i]  = '0;
    end
    @(negedge clk);
    test_reset();
    test_basic();
    test_conflict();
    test_collision();
    test_reset_mid();
    test_tag_width();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
